// File: rtl/cal_defines.sv
// Shared definitions for the BCD calculator execution controller.
// Holds op codes, one-hot state constants, datapath widths, iteration
// terminal counts and the 3-digit BCD to binary helper.
package cal_defines;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned RES_DIGITS = 6;
  localparam int unsigned BCD_IN_W   = 3 * DIGIT_W;
  localparam int unsigned BIN_W      = 10;
  localparam int unsigned AS_W       = BIN_W + 1;
  localparam int unsigned RES_BIN_W  = 20;
  localparam int unsigned RES_BCD_W  = RES_DIGITS * DIGIT_W;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned STATE_W    = 5;

  // Terminal counts: 10 mul/div iterations, 20 double-dabble iterations
  localparam logic [CNT_W-1:0] MULDIV_LAST = CNT_W'(9);
  localparam logic [CNT_W-1:0] BCD_LAST    = CNT_W'(19);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  localparam logic [STATE_W-1:0] ST_IDLE = 5'b00001;
  localparam logic [STATE_W-1:0] ST_CONV = 5'b00010;
  localparam logic [STATE_W-1:0] ST_CALC = 5'b00100;
  localparam logic [STATE_W-1:0] ST_BCD  = 5'b01000;
  localparam logic [STATE_W-1:0] ST_DONE = 5'b10000;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = ST_IDLE,
    S_CONV = ST_CONV,
    S_CALC = ST_CALC,
    S_BCD  = ST_BCD,
    S_DONE = ST_DONE
  } state_e;

  // d2*100 + d1*10 + d0
  function automatic logic [BIN_W-1:0] bcd3_to_bin(input logic [BCD_IN_W-1:0] v);
    return BIN_W'(v[2*DIGIT_W +: DIGIT_W]) * BIN_W'(100)
         + BIN_W'(v[DIGIT_W +: DIGIT_W]) * BIN_W'(10)
         + BIN_W'(v[0 +: DIGIT_W]);
  endfunction

endpackage

// File: rtl/cal_bin2bcd.sv
// Sequential double-dabble converter: 20-bit binary to 6 BCD digits,
// one shift per cycle for 20 cycles after a load pulse.
// Ports: clk, rst (sync), load (capture bin, clear digits), bin (value),
//        busy (conversion in progress), bcd (digit register, final when busy falls).
module cal_bin2bcd
  import cal_defines::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [RES_BIN_W-1:0] bin,
  output logic                 busy,
  output logic [RES_BCD_W-1:0] bcd
);

  logic [RES_BIN_W-1:0] sh_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [RES_BCD_W-1:0] adj_c;

  // Add 3 to every digit >= 5 ahead of the shift
  always_comb begin
    adj_c = bcd;
    for (int i = 0; i < int'(RES_DIGITS); i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] > 4'd4)
        adj_c[i*DIGIT_W +: DIGIT_W] = bcd[i*DIGIT_W +: DIGIT_W] + 4'd3;
    end
  end

  // Shift the binary MSB into the digit LSB each busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      bcd   <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      sh_q  <= bin;
      bcd   <= '0;
      cnt_q <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      {bcd, sh_q} <= {adj_c[RES_BCD_W-2:0], sh_q, 1'b0};
      if (cnt_q == BCD_LAST) busy  <= 1'b0;
      else                   cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dflip_en.sv
// Enable-gated register cell with synchronous active-high clear.
// Ports: clk, rst (sync clear), en (load enable), d (data in), q (data out).
module dflip_en #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cal_exe_ctrl.sv
// Execution controller for a 3-digit signed BCD calculator.
// Sequence IDLE -> CONV -> CALC -> BCD -> DONE: latch request, convert
// operands to binary, add/sub (1 cycle) or shift-add mul / restoring div
// (10 cycles), then double-dabble back to 6 BCD digits (20 cycles).
// Inputs : clk, rst (sync, active-high), start, op, a_bcd/a_sign,
//          b_bcd/b_sign, ack.
// Outputs: busy (not IDLE), done (in DONE), err (divide by zero),
//          res_bcd/res_sign (signed result, valid while done).
module cal_exe_ctrl
  import cal_defines::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [BCD_IN_W-1:0]  a_bcd,
  input  logic                 a_sign,
  input  logic [BCD_IN_W-1:0]  b_bcd,
  input  logic                 b_sign,
  input  logic                 ack,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [RES_BCD_W-1:0] res_bcd,
  output logic                 res_sign
);

  localparam int unsigned OPND_W  = 2 + 2 * BCD_IN_W + 2;
  localparam logic [3:0]  DIV_TOP = 4'(BIN_W - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q;
  logic [BCD_IN_W-1:0]  a_bcd_q, b_bcd_q;
  logic                 a_sign_q, b_sign_q;
  logic [BIN_W-1:0]     a_bin_q, b_bin_q;
  logic [RES_BIN_W-1:0] prod_q, prod_d;
  logic [BIN_W-1:0]     rem_q, rem_d, quo_q, quo_d;
  logic                 err_q, err_d, sign_q, sign_d;
  logic                 accept_c;
  logic                 eff_b_sign_c, as_sign_c;
  logic [AS_W-1:0]      as_mag_c;
  logic [AS_W-1:0]      rem_sh_c;
  logic [3:0]           div_idx_c;
  logic [RES_BIN_W-1:0] mag_c;
  logic                 raw_sign_c, calc_last_c;
  logic                 b2b_load_c, b2b_busy;
  logic [RES_BIN_W-1:0] b2b_bin_c;

  assign accept_c = (state_q == S_IDLE) && start;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign res_sign = sign_q;

  // Request latch: only written when a start is accepted in IDLE
  dflip_en #(.W(OPND_W)) u_opnd (
    .clk (clk),
    .rst (rst),
    .en  (accept_c),
    .d   ({op, a_bcd, a_sign, b_bcd, b_sign}),
    .q   ({op_q, a_bcd_q, a_sign_q, b_bcd_q, b_sign_q})
  );

  // Binary operands captured during CONV
  dflip_en #(.W(2 * BIN_W)) u_bin (
    .clk (clk),
    .rst (rst),
    .en  (state_q == S_CONV),
    .d   ({bcd3_to_bin(a_bcd_q), bcd3_to_bin(b_bcd_q)}),
    .q   ({a_bin_q, b_bin_q})
  );

  // Sign-magnitude add/sub: sub flips B's sign, then add or subtract magnitudes
  always_comb begin
    eff_b_sign_c = b_sign_q ^ (op_q == OP_SUB);
    as_mag_c     = '0;
    as_sign_c    = 1'b0;
    if (a_sign_q == eff_b_sign_c) begin
      as_mag_c  = AS_W'(a_bin_q) + AS_W'(b_bin_q);
      as_sign_c = a_sign_q;
    end else if (a_bin_q >= b_bin_q) begin
      as_mag_c  = AS_W'(a_bin_q - b_bin_q);
      as_sign_c = a_sign_q;
    end else begin
      as_mag_c  = AS_W'(b_bin_q - a_bin_q);
      as_sign_c = eff_b_sign_c;
    end
  end

  // Next-state, iteration datapath and converter load
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    err_d       = err_q;
    sign_d      = sign_q;
    rem_sh_c    = '0;
    div_idx_c   = '0;
    mag_c       = '0;
    raw_sign_c  = 1'b0;
    calc_last_c = 1'b0;
    b2b_load_c  = 1'b0;
    b2b_bin_c   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONV;
          err_d   = 1'b0;
          sign_d  = 1'b0;
        end
      end
      S_CONV: begin
        cnt_d  = '0;
        prod_d = '0;
        rem_d  = '0;
        quo_d  = '0;
        if (op_q == OP_DIV && b_bcd_q == '0) begin
          // Divide by zero skips straight to DONE with a zero result
          state_d    = S_DONE;
          err_d      = 1'b1;
          sign_d     = 1'b0;
          b2b_load_c = 1'b1;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            mag_c       = RES_BIN_W'(as_mag_c);
            raw_sign_c  = as_sign_c;
            calc_last_c = 1'b1;
          end
          OP_MUL: begin
            prod_d      = prod_q + (b_bin_q[cnt_q[3:0]] ? (RES_BIN_W'(a_bin_q) << cnt_q) : '0);
            mag_c       = prod_d;
            raw_sign_c  = a_sign_q ^ b_sign_q;
            calc_last_c = (cnt_q == MULDIV_LAST);
          end
          OP_DIV: begin
            // Restoring division: bring down dividend bits MSB first
            div_idx_c = DIV_TOP - cnt_q[3:0];
            rem_sh_c  = {rem_q, a_bin_q[div_idx_c]};
            if (rem_sh_c >= AS_W'(b_bin_q)) begin
              rem_d = BIN_W'(rem_sh_c - AS_W'(b_bin_q));
              quo_d = BIN_W'({quo_q, 1'b1});
            end else begin
              rem_d = BIN_W'(rem_sh_c);
              quo_d = BIN_W'({quo_q, 1'b0});
            end
            mag_c       = RES_BIN_W'(quo_d);
            raw_sign_c  = a_sign_q ^ b_sign_q;
            calc_last_c = (cnt_q == MULDIV_LAST);
          end
        endcase
        if (calc_last_c) begin
          state_d    = S_BCD;
          cnt_d      = '0;
          b2b_load_c = 1'b1;
          b2b_bin_c  = mag_c;
          sign_d     = (mag_c != '0) && raw_sign_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BCD: begin
        if (cnt_q == BCD_LAST && b2b_busy) state_d = S_DONE;
        else                               cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      err_q   <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      err_q   <= err_d;
      sign_q  <= sign_d;
    end
  end

  cal_bin2bcd u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .load (b2b_load_c),
    .bin  (b2b_bin_c),
    .busy (b2b_busy),
    .bcd  (res_bcd)
  );

endmodule

// File: tb/tb_cal_exe_ctrl.sv
// Scoreboard bench for cal_exe_ctrl: a driver issues requests and queues
// the expected signed decimal result and DONE edge; a monitor pops and
// compares whenever done rises and checks the result stays held.
module tb_cal_exe_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, ack, a_sign, b_sign;
  logic [1:0]  op;
  logic [11:0] a_bcd, b_bcd;
  logic        busy, done, err, res_sign;
  logic [23:0] res_bcd;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [23:0] bcd;
    logic        sign;
    logic        err;
    int          done_edge;
  } exp_t;

  exp_t exp_q[$];

  cal_exe_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a_bcd    (a_bcd),
    .a_sign   (a_sign),
    .b_bcd    (b_bcd),
    .b_sign   (b_sign),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .res_bcd  (res_bcd),
    .res_sign (res_sign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  function automatic logic [11:0] to_bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] to_bcd6(input int v);
    logic [23:0] r;
    int m;
    r = '0;
    m = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Reference: plain signed integer arithmetic, truncating division
  function automatic void model(input logic [1:0] o, input int a, input bit as,
                                input int b, input bit bs, output exp_t e, output int lat);
    int sa, sb, r;
    sa = as ? -a : a;
    sb = bs ? -b : b;
    e.err = 1'b0;
    r = 0;
    lat = 31;
    case (o)
      2'd0: begin r = sa + sb; lat = 22; end
      2'd1: begin r = sa - sb; lat = 22; end
      2'd2: r = sa * sb;
      default: begin
        if (b == 0) begin e.err = 1'b1; lat = 1; end
        else r = sa / sb;
      end
    endcase
    e.sign = (r < 0);
    e.bcd  = to_bcd6(r < 0 ? -r : r);
    e.done_edge = 0;
  endfunction

  // Monitor: compare on done rising, then require the result to stay put
  logic done_prev = 1'b0;
  bit   have_cur  = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (done === 1'b1 && done_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        have_cur = 1'b0;
        $display("FAIL spurious_done: done rose at edge %0d with nothing pending", edge_cnt);
      end else begin
        cur = exp_q.pop_front();
        have_cur = 1'b1;
        chk("done_edge", 32'(edge_cnt), 32'(cur.done_edge));
        chk("res_bcd", 32'(res_bcd), 32'(cur.bcd));
        chk("res_sign", 32'(res_sign), 32'(cur.sign));
        chk("err", 32'(err), 32'(cur.err));
        chk("busy_in_done", 32'(busy), 32'd1);
      end
    end else if (done === 1'b1 && have_cur) begin
      chk("hold_bcd", 32'(res_bcd), 32'(cur.bcd));
      chk("hold_sign", 32'(res_sign), 32'(cur.sign));
      chk("hold_err", 32'(err), 32'(cur.err));
    end
    done_prev = done;
  end

  task automatic scramble_inputs();
    op     = 2'($urandom);
    a_bcd  = to_bcd3(int'($urandom_range(0, 999)));
    b_bcd  = to_bcd3(int'($urandom_range(0, 999)));
    a_sign = 1'($urandom);
    b_sign = 1'($urandom);
  endtask

  task automatic run_op(input logic [1:0] o, input int a, input bit as, input int b,
                        input bit bs, input bit dup, input bit ack_start);
    exp_t e;
    int   lat;
    int   k;
    model(o, a, as, b, bs, e, lat);
    @(negedge clk);
    op = o; a_bcd = to_bcd3(a); a_sign = as; b_bcd = to_bcd3(b); b_sign = bs;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.done_edge = edge_cnt + lat;
    exp_q.push_back(e);
    scramble_inputs();
    if (dup && lat > 1) begin
      // Stray start and ack at edge N+5 while busy must both be ignored
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      ack   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ack   = 1'b0;
    end
    k = 0;
    while (done !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected high", done, k);
      return;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    ack   = 1'b1;
    start = ack_start;
    @(posedge clk);
    #1;
    ack   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("ack_idle_done", 32'(done), 32'd0);
    chk("ack_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_reset_mid_mul();
    @(negedge clk);
    op = 2'd2; a_bcd = to_bcd3(999); a_sign = 1'b1; b_bcd = to_bcd3(999); b_sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_res_bcd", 32'(res_bcd), 32'd0);
    chk("rst_res_sign", 32'(res_sign), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int o, a, b;
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    op = '0; a_bcd = '0; b_bcd = '0; a_sign = 1'b0; b_sign = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_err", 32'(err), 32'd0);
    chk("init_res_bcd", 32'(res_bcd), 32'd0);
    chk("init_res_sign", 32'(res_sign), 32'd0);
    rst = 1'b0;

    run_op(2'd0, 123, 1'b0, 45, 1'b1, 1'b0, 1'b0);
    run_op(2'd2, 999, 1'b0, 999, 1'b0, 1'b0, 1'b0);
    run_op(2'd3, 999, 1'b1, 7, 1'b0, 1'b0, 1'b0);
    run_op(2'd3, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_op(2'd1, 12, 1'b1, 12, 1'b1, 1'b1, 1'b0);
    run_reset_mid_mul();
    run_op(2'd0, 456, 1'b1, 789, 1'b0, 1'b0, 1'b0);
    run_op(2'd0, 999, 1'b0, 999, 1'b0, 1'b0, 1'b1);
    run_op(2'd1, 0, 1'b0, 999, 1'b0, 1'b1, 1'b1);
    run_op(2'd2, 0, 1'b1, 512, 1'b0, 1'b0, 1'b0);
    run_op(2'd3, 3, 1'b1, 7, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      o = int'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 999));
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 999));
      if (o == 3 && $urandom_range(0, 4) == 0) b = 0;
      run_op(2'(o), a, 1'($urandom), b, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", edge_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cal_exe_ctrl.md
CAL_EXE_CTRL -- requirements
Module: cal_exe_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed by the shared package.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle request to execute; qualified only in IDLE.
REQ-005 op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 a_bcd  in  12  operand A magnitude, 3 BCD digits {d2,d1,d0}, each 0-9.
REQ-007 a_sign  in  1  operand A sign, 1 = negative.
REQ-008 b_bcd  in  12  operand B magnitude, same format as a_bcd.
REQ-009 b_sign  in  1  operand B sign.
REQ-010 ack  in  1  one-cycle acknowledge of the result; qualified only in DONE.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  high exactly while in DONE.
REQ-013 err  out  1  divide-by-zero flag, valid while done.
REQ-014 res_bcd  out  24  result magnitude, 6 BCD digits, valid while done.
REQ-015 res_sign  out  1  result sign, valid while done.

Function
REQ-016 SHALL implement one-hot FSM IDLE -> CONV -> CALC -> BCD -> DONE -> IDLE.
REQ-017 IDLE: start=1 at edge N latches op, operands, signs, and enters CONV at edge N.
REQ-018 CONV: one cycle; converts each operand to a 10-bit binary as d2*100+d1*10+d0.
REQ-019 CONV with op=div and B magnitude 0: enters DONE next edge with err=1, res_bcd=0, res_sign=0.
REQ-020 CALC add/sub: one cycle; signed sum/difference of sign-magnitude operands; 11-bit magnitude, max 1998.
REQ-021 CALC mul: 10-cycle shift-add on magnitudes; 20-bit product, max 998001; sign = a_sign XOR b_sign.
REQ-022 CALC div: 10-cycle restoring division of magnitudes; quotient truncated toward zero; remainder discarded; sign = a_sign XOR b_sign.
REQ-023 BCD: 20-cycle double-dabble conversion of the 20-bit magnitude (zero-extended) into res_bcd.
REQ-024 Zero magnitude result SHALL force res_sign=0.
REQ-025 Latency from the start-sampling edge N to DONE entry SHALL be: add/sub N+22; mul/div N+31; divide-by-zero N+1.
REQ-026 DONE: done, err, res_bcd and res_sign are held stable until ack=1, then IDLE on the next edge.
REQ-027 start while busy SHALL be ignored and SHALL NOT alter latched operands.
REQ-028 ack outside DONE SHALL be ignored.
REQ-029 start and ack in the same DONE cycle: ack is taken; start is dropped.
REQ-030 Iteration counters SHALL be 5 bits, cleared on entry to CALC and BCD; no wrap-around beyond the terminal count.

Reset
REQ-031 rst=1 SHALL force IDLE on the next edge from any state, including mid-CALC and mid-BCD.
REQ-032 After reset: busy=0, done=0, err=0, res_bcd=0, res_sign=0, counters=0, latched operands=0.

Structure
REQ-033 Op codes, one-hot state constants, state width, and digit/operand/result widths SHALL live in the shared cal_defines package.
REQ-034 Double-dabble SHALL be a sub-module cal_bin2bcd with a load/busy interface, instantiated once.
REQ-035 Sequential elements SHALL use the existing dflip_en register cell where enable-gated.

Verification
REQ-036 A=123, B=-45, add -> DONE at N+22, res_bcd=000078, res_sign=0, err=0.
REQ-037 A=999, B=999, mul -> DONE at N+31, res_bcd=998001, res_sign=0.
REQ-038 A=-999, B=7, div -> DONE at N+31, res_bcd=000142, res_sign=1.
REQ-039 A=5, B=0, div -> DONE at N+1, err=1, res_bcd=0; ack -> IDLE next edge.
REQ-040 A=-12, B=-12, sub -> res_bcd=0, res_sign=0; a second start pulse at N+5 is ignored, with no change to the result or latency.
REQ-041 rst asserted at N+10 of a mul -> IDLE, all outputs 0 next edge; a fresh add then completes with the correct value.
